// File: rtl/gbt_frame_pipe_pkg.sv
// Shared types and helpers for the GBT frame pipe: TX mode and checker state encodings,
// header width and the data-field extractor.
package gbt_frame_pipe_pkg;

  localparam int unsigned C_GBT_HDR_W = 4;
  // Widest frame the extractor accepts (data up to 256 bits plus header)
  localparam int unsigned C_MAX_FW    = 260;

  typedef enum logic [1:0] {
    ModeUser = 2'b00,
    ModeLoop = 2'b01,
    ModeCnt  = 2'b10,
    ModeIdle = 2'b11
  } t_pipe_mode;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StLocked
  } t_chk_state;

  // Frame layout is {sc, ic, data}; keep only the low w data bits.
  function automatic logic [C_MAX_FW-1:0] frame_data(input logic [C_MAX_FW-1:0] frame,
                                                     input int unsigned w);
    logic [C_MAX_FW-1:0] res;
    for (int unsigned i = 0; i < C_MAX_FW; i++) begin
      res[i] = (i < w) ? frame[i] : 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/gbt_frame_pipe_if.sv
// Bus bundle between system logic and gbt_frame_pipe. err_inject_i only exists when
// GBT_FRAME_PIPE_ERR_INJECT_EN is defined.
interface gbt_frame_pipe_if #(
  parameter int unsigned G_CHANNELS     = 1,
  parameter int unsigned G_DATA_WIDTH   = 80,
  parameter int unsigned G_ERRCNT_WIDTH = 16
);
  import gbt_frame_pipe_pkg::*;

  localparam int unsigned FW = G_DATA_WIDTH + C_GBT_HDR_W;

  logic [G_CHANNELS*FW-1:0]             user_frame_ib;
  logic [G_CHANNELS*FW-1:0]             rx_frame_ib;
  logic [G_CHANNELS-1:0]                rx_valid_i;
  logic [2*G_CHANNELS-1:0]              mode_ib;
  logic [G_CHANNELS-1:0]                chk_en_i;
  logic [G_CHANNELS-1:0]                chk_clr_i;
`ifdef GBT_FRAME_PIPE_ERR_INJECT_EN
  logic [G_CHANNELS-1:0]                err_inject_i;
`endif
  logic [G_CHANNELS*FW-1:0]             tx_frame_ob;
  logic [G_CHANNELS-1:0]                chk_locked_o;
  logic [G_CHANNELS*G_ERRCNT_WIDTH-1:0] chk_errcnt_ob;

  modport master (
`ifdef GBT_FRAME_PIPE_ERR_INJECT_EN
    output err_inject_i,
`endif
    output user_frame_ib, rx_frame_ib, rx_valid_i, mode_ib, chk_en_i, chk_clr_i,
    input  tx_frame_ob, chk_locked_o, chk_errcnt_ob
  );

  modport slave (
`ifdef GBT_FRAME_PIPE_ERR_INJECT_EN
    input  err_inject_i,
`endif
    input  user_frame_ib, rx_frame_ib, rx_valid_i, mode_ib, chk_en_i, chk_clr_i,
    output tx_frame_ob, chk_locked_o, chk_errcnt_ob
  );

endinterface

// File: rtl/gbt_frame_pipe_checker.sv
// Per-channel RX counter-pattern checker: search/lock FSM on the data field plus a
// saturating error counter that survives unlock and disable.
module gbt_frame_pipe_checker
  import gbt_frame_pipe_pkg::*;
#(
  parameter int unsigned G_DATA_WIDTH   = 80,
  parameter int unsigned G_LOCK_COUNT   = 4,
  parameter int unsigned G_UNLOCK_COUNT = 4,
  parameter int unsigned G_ERRCNT_WIDTH = 16
) (
  input  logic                      clk_ik,
  input  logic                      rst_nir,
  input  logic [G_DATA_WIDTH-1:0]   rx_data,
  input  logic                      rx_valid,
  input  logic                      chk_en,
  input  logic                      chk_clr,
  output logic                      locked,
  output logic [G_ERRCNT_WIDTH-1:0] errcnt
);

  localparam int unsigned W      = G_DATA_WIDTH;
  localparam int unsigned EW     = G_ERRCNT_WIDTH;
  localparam int unsigned MaxCnt = (G_LOCK_COUNT > G_UNLOCK_COUNT) ? G_LOCK_COUNT
                                                                   : G_UNLOCK_COUNT;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  t_chk_state      state_q;
  logic            seeded_q;
  logic [W-1:0]    exp_q;
  logic [CntW-1:0] match_q;
  logic [CntW-1:0] miss_q;
  logic [EW-1:0]   err_q;
  logic            locked_q;
  logic            hit;
  logic            err_inc;

  assign hit     = (rx_data == exp_q);
  assign err_inc = chk_en && (state_q == StLocked) && rx_valid && !hit && !(&err_q);

  always_ff @(posedge clk_ik or negedge rst_nir) begin
    if (!rst_nir) begin
      state_q  <= StIdle;
      seeded_q <= 1'b0;
      exp_q    <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      err_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      if (!chk_en) begin
        state_q  <= StIdle;
        seeded_q <= 1'b0;
        match_q  <= '0;
        miss_q   <= '0;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            state_q  <= StSearch;
            seeded_q <= 1'b0;
            match_q  <= '0;
          end
          StSearch: begin
            if (rx_valid) begin
              if (seeded_q && hit) begin
                exp_q   <= exp_q + W'(1);
                match_q <= match_q + CntW'(1);
                if (match_q == CntW'(G_LOCK_COUNT - 1)) begin
                  state_q  <= StLocked;
                  locked_q <= 1'b1;
                  miss_q   <= '0;
                end
              end else begin
                // First frame, or a break in the sequence: re-seed from what arrived
                exp_q    <= rx_data + W'(1);
                seeded_q <= 1'b1;
                match_q  <= '0;
              end
            end
          end
          StLocked: begin
            if (rx_valid) begin
              exp_q <= exp_q + W'(1);
              if (hit) begin
                miss_q <= '0;
              end else if (miss_q == CntW'(G_UNLOCK_COUNT - 1)) begin
                state_q  <= StSearch;
                locked_q <= 1'b0;
                seeded_q <= 1'b0;
                match_q  <= '0;
                miss_q   <= '0;
              end else begin
                miss_q <= miss_q + CntW'(1);
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
      // Clear has priority over a coincident mismatch
      if (chk_clr) begin
        err_q <= '0;
      end else if (err_inc) begin
        err_q <= err_q + EW'(1);
      end
    end
  end

  assign locked = locked_q;
  assign errcnt = err_q;

endmodule

// File: rtl/gbt_frame_pipe.sv
// Multi-channel GBT frame source/sink: per-channel TX mux (user/loopback/counter/idle) and
// RX pattern checker. Define GBT_FRAME_PIPE_ERR_INJECT_EN to add counter-frame error injection.
module gbt_frame_pipe
  import gbt_frame_pipe_pkg::*;
#(
  parameter int unsigned G_CHANNELS     = 1,
  parameter int unsigned G_DATA_WIDTH   = 80,
  parameter int unsigned G_LOOP_LATENCY = 1,
  parameter int unsigned G_LOCK_COUNT   = 4,
  parameter int unsigned G_UNLOCK_COUNT = 4,
  parameter int unsigned G_ERRCNT_WIDTH = 16
) (
  input logic             clk_ik,
  input logic             rst_nir,
  gbt_frame_pipe_if.slave bus
);

  localparam int unsigned W  = G_DATA_WIDTH;
  localparam int unsigned FW = W + C_GBT_HDR_W;

  if (G_LOOP_LATENCY < 1) begin : g_bad_latency
    $error("gbt_frame_pipe: G_LOOP_LATENCY must be >= 1");
  end

  for (genvar c = 0; c < G_CHANNELS; c++) begin : g_ch
    t_pipe_mode    mode;
    t_pipe_mode    mode_q;
    logic [W-1:0]  gen_cnt_q;
    logic [W-1:0]  gen_cnt_d;
    logic [W-1:0]  cnt_data;
    logic [W-1:0]  rx_data;
    logic [FW-1:0] loop_in;
    logic [FW-1:0] loop_out;
    logic [FW-1:0] tx_d;
    logic [FW-1:0] tx_q;
    logic          inject;

    assign mode    = t_pipe_mode'(bus.mode_ib[2*c +: 2]);
    assign loop_in = bus.rx_valid_i[c] ? bus.rx_frame_ib[c*FW +: FW] : '0;
    assign rx_data = W'(frame_data(C_MAX_FW'(bus.rx_frame_ib[c*FW +: FW]), W));

`ifdef GBT_FRAME_PIPE_ERR_INJECT_EN
    assign inject = bus.err_inject_i[c];
`else
    assign inject = 1'b0;
`endif

    // tx_q is the last loopback stage, so only G_LOOP_LATENCY-1 extra stages live here
    if (G_LOOP_LATENCY == 1) begin : g_loop_direct
      assign loop_out = loop_in;
    end else begin : g_loop_pipe
      localparam int unsigned PipeDepth = G_LOOP_LATENCY - 1;
      logic [FW-1:0] pipe_q [PipeDepth];

      always_ff @(posedge clk_ik or negedge rst_nir) begin
        if (!rst_nir) begin
          for (int unsigned i = 0; i < PipeDepth; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          pipe_q[0] <= loop_in;
          for (int unsigned i = 1; i < PipeDepth; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      assign loop_out = pipe_q[PipeDepth-1];
    end

    always_comb begin
      // Entering counter mode restarts the sequence at 0
      cnt_data  = (mode_q == ModeCnt) ? gen_cnt_q : '0;
      gen_cnt_d = '0;
      tx_d      = '0;
      case (mode)
        ModeUser: tx_d = bus.user_frame_ib[c*FW +: FW];
        ModeLoop: tx_d = loop_out;
        ModeCnt: begin
          gen_cnt_d = cnt_data + W'(1);
          tx_d      = {{C_GBT_HDR_W{1'b0}}, cnt_data ^ W'(inject)};
        end
        default: tx_d = '0;
      endcase
    end

    always_ff @(posedge clk_ik or negedge rst_nir) begin
      if (!rst_nir) begin
        mode_q    <= ModeIdle;
        gen_cnt_q <= '0;
        tx_q      <= '0;
      end else begin
        mode_q    <= mode;
        gen_cnt_q <= gen_cnt_d;
        tx_q      <= tx_d;
      end
    end

    assign bus.tx_frame_ob[c*FW +: FW] = tx_q;

    gbt_frame_pipe_checker #(
      .G_DATA_WIDTH  (G_DATA_WIDTH),
      .G_LOCK_COUNT  (G_LOCK_COUNT),
      .G_UNLOCK_COUNT(G_UNLOCK_COUNT),
      .G_ERRCNT_WIDTH(G_ERRCNT_WIDTH)
    ) u_checker (
      .clk_ik  (clk_ik),
      .rst_nir (rst_nir),
      .rx_data (rx_data),
      .rx_valid(bus.rx_valid_i[c]),
      .chk_en  (bus.chk_en_i[c]),
      .chk_clr (bus.chk_clr_i[c]),
      .locked  (bus.chk_locked_o[c]),
      .errcnt  (bus.chk_errcnt_ob[c*G_ERRCNT_WIDTH +: G_ERRCNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_gbt_frame_pipe.sv
// Directed bench for gbt_frame_pipe: 2 channels, 8-bit data, loop latency 3, 4-bit error count.
module tb_gbt_frame_pipe;

  localparam int unsigned CH = 2;
  localparam int unsigned W  = 8;
  localparam int unsigned FW = 12;
  localparam int unsigned EW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gbt_frame_pipe_if #(.G_CHANNELS(CH), .G_DATA_WIDTH(W), .G_ERRCNT_WIDTH(EW)) bus ();

  gbt_frame_pipe #(
    .G_CHANNELS    (CH),
    .G_DATA_WIDTH  (W),
    .G_LOOP_LATENCY(3),
    .G_LOCK_COUNT  (4),
    .G_UNLOCK_COUNT(4),
    .G_ERRCNT_WIDTH(EW)
  ) dut (
    .clk_ik (clk),
    .rst_nir(rst_n),
    .bus    (bus)
  );

  logic          loop0;
  logic [FW-1:0] rx0_val;
  logic [FW-1:0] rx1_val;
  logic [FW-1:0] tx0;
  logic [FW-1:0] tx1;
  logic [EW-1:0] err0;
  logic          lk0;

  // Channel 0 RX can be looped from its own TX, channel 1 RX is driven directly
  assign bus.rx_frame_ib = {rx1_val, loop0 ? bus.tx_frame_ob[FW-1:0] : rx0_val};
  assign tx0  = bus.tx_frame_ob[FW-1:0];
  assign tx1  = bus.tx_frame_ob[2*FW-1:FW];
  assign err0 = bus.chk_errcnt_ob[EW-1:0];
  assign lk0  = bus.chk_locked_o[0];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [FW-1:0] v1 [8] = '{12'hA5A, 12'h5A5, 12'hFA5, 12'h0A5,
                            12'hCA7, 12'hA55, 12'h1A5, 12'hEA5};
  logic [7:0]    vld    = 8'b1011_0101;
  logic [FW-1:0] hist [12];
  logic [7:0]    exp_tx;
  logic [7:0]    cur;
  logic [7:0]    t;
  logic [FW-1:0] u0;

  initial begin
    rst_n             = 1'b0;
    loop0             = 1'b0;
    rx0_val           = '0;
    rx1_val           = '0;
    bus.user_frame_ib = '0;
    bus.rx_valid_i    = '0;
    bus.mode_ib       = 4'b1111;
    bus.chk_en_i      = '0;
    bus.chk_clr_i     = '0;
`ifdef GBT_FRAME_PIPE_ERR_INJECT_EN
    bus.err_inject_i  = '0;
`endif

    // Reset state
    repeat (3) tick();
    check_eq("rst_tx", bus.tx_frame_ob, 0);
    check_eq("rst_locked", bus.chk_locked_o, 0);
    check_eq("rst_errcnt", bus.chk_errcnt_ob, 0);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_tx", bus.tx_frame_ob, 0);
    check_eq("post_rst_locked", bus.chk_locked_o, 0);
    check_eq("post_rst_errcnt", bus.chk_errcnt_ob, 0);

    // Channel 0 counter pattern looped back into its own checker
    bus.mode_ib[1:0] = 2'b10;
    bus.rx_valid_i   = 2'b01;
    bus.chk_en_i     = 2'b01;
    loop0            = 1'b1;
    exp_tx           = 8'h00;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("cnt_tx", tx0, {4'h0, exp_tx});
      exp_tx++;
      if (k == 4) check_eq("not_yet_locked", lk0, 0);
      if (k == 5) check_eq("locked", lk0, 1);
    end
    for (int k = 0; k < 1000; k++) begin
      tick();
      check_eq("cnt_run_tx", tx0, {4'h0, exp_tx});
      exp_tx++;
    end
    check_eq("run_locked", lk0, 1);
    check_eq("run_errcnt", err0, 0);

    // Single +2 jump, then back on sequence
    t       = exp_tx - 8'd1;
    loop0   = 1'b0;
    rx0_val = {4'h0, t + 8'd2};
    tick();
    rx0_val = {4'h0, t + 8'd1};
    tick();
    check_eq("jump_errcnt", err0, 1);
    check_eq("jump_locked", lk0, 1);
    cur = t + 8'd2;

    // Four wrong frames in a row drop lock
    for (int i = 0; i < 4; i++) begin
      rx0_val = {4'h0, cur ^ 8'h80};
      cur++;
      tick();
      if (i == 2) begin
        check_eq("miss3_locked", lk0, 1);
        check_eq("miss3_errcnt", err0, 4);
      end
    end
    check_eq("unlock_locked", lk0, 0);
    check_eq("unlock_errcnt", err0, 5);

    // Re-lock on a fresh sequence with sc/ic bits set (must be ignored)
    for (int i = 0; i < 5; i++) begin
      rx0_val = {4'hF, 8'h40 + 8'(i)};
      tick();
      if (i == 3) check_eq("relock_early", lk0, 0);
    end
    check_eq("relock_locked", lk0, 1);
    check_eq("relock_errcnt", err0, 5);
    cur = 8'h45;

    // Three misses per group of four keep lock while pushing errcnt into saturation
    for (int i = 0; i < 24; i++) begin
      rx0_val = {4'h0, ((i % 4) != 3) ? (cur ^ 8'h80) : cur};
      cur++;
      tick();
      if (i == 11) check_eq("sat_mid_errcnt", err0, 14);
    end
    check_eq("sat_errcnt", err0, 15);
    check_eq("sat_locked", lk0, 1);

    // Clear coincident with a mismatch
    rx0_val          = {4'h0, cur ^ 8'h80};
    bus.chk_clr_i[0] = 1'b1;
    cur++;
    tick();
    bus.chk_clr_i[0] = 1'b0;
    check_eq("clr_wins_errcnt", err0, 0);
    rx0_val = {4'h0, cur};
    cur++;
    tick();
    check_eq("clr_good_errcnt", err0, 0);
    check_eq("clr_good_locked", lk0, 1);
    rx0_val = {4'h0, cur ^ 8'h80};
    cur++;
    tick();
    check_eq("post_clr_errcnt", err0, 1);

    // Disable drops lock, holds errcnt, stops comparing
    bus.chk_en_i[0] = 1'b0;
    rx0_val         = {4'h0, cur ^ 8'h80};
    tick();
    check_eq("dis_locked", lk0, 0);
    check_eq("dis_errcnt", err0, 1);
    tick();
    check_eq("idle_errcnt", err0, 1);

    // Channel 1 loopback with gaps, channel 0 in user mode
    u0                    = 12'h5C3;
    bus.user_frame_ib     = {12'h777, u0};
    bus.mode_ib           = 4'b0100;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin
        rx1_val           = v1[i];
        bus.rx_valid_i[1] = vld[i];
        hist[i]           = vld[i] ? v1[i] : '0;
      end else begin
        rx1_val           = 12'hFFF;
        bus.rx_valid_i[1] = 1'b0;
        hist[i]           = '0;
      end
      if (i == 5) begin
        u0                     = 12'hA3C;
        bus.user_frame_ib[11:0] = u0;
      end
      tick();
      check_eq("loop_tx1", tx1, (i >= 2) ? hist[i-2] : 12'h000);
      check_eq("user_tx0", tx0, u0);
    end

    // Idle, then counter restart on re-entry
    bus.mode_ib[3:2] = 2'b11;
    tick();
    check_eq("idle_tx1", tx1, 0);
    bus.mode_ib[3:2] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("cnt1_tx", tx1, i);
    end
    bus.mode_ib[3:2] = 2'b00;
    tick();
    check_eq("user1_tx", tx1, 12'h777);
    bus.mode_ib[3:2] = 2'b10;
    tick();
    check_eq("cnt1_restart", tx1, 0);
    tick();
    check_eq("cnt1_next", tx1, 1);

    // Channel 0 back to counter loopback
    bus.mode_ib[1:0] = 2'b10;
    loop0            = 1'b1;
    bus.chk_en_i[0]  = 1'b1;
    exp_tx           = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq("relock_tx", tx0, {4'h0, exp_tx});
      exp_tx++;
    end
    check_eq("relock_cnt_locked", lk0, 1);

`ifdef GBT_FRAME_PIPE_ERR_INJECT_EN
    bus.chk_clr_i[0] = 1'b1;
    tick();
    bus.chk_clr_i[0] = 1'b0;
    exp_tx++;
    check_eq("inj_clr_errcnt", err0, 0);
    for (int j = 0; j < 3; j++) begin
      bus.err_inject_i[0] = 1'b1;
      tick();
      bus.err_inject_i[0] = 1'b0;
      check_eq("inj_frame", tx0, {4'h0, exp_tx ^ 8'h01});
      exp_tx++;
      for (int k = 0; k < 9; k++) begin
        tick();
        check_eq("inj_seq", tx0, {4'h0, exp_tx});
        exp_tx++;
      end
    end
    check_eq("inj_errcnt", err0, 3);
    check_eq("inj_locked", lk0, 1);
`endif

    check_eq("ch1_errcnt", bus.chk_errcnt_ob[2*EW-1:EW], 0);

    // Asynchronous reset mid-lock, away from the clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_tx", bus.tx_frame_ob, 0);
    check_eq("async_rst_locked", bus.chk_locked_o, 0);
    check_eq("async_rst_errcnt", bus.chk_errcnt_ob, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
